// File: rtl/sw_bist_pkg.sv
// Shared types and helpers for the switch self-test checker.
package sw_bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_TEST,
    S_PASS,
    S_FAIL
  } state_t;

  localparam logic [15:0] LED_ALL = 16'hFFFF;

  // Bits needed to hold any value in 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sw_debounce.sv
// 16-bit switch synchronizer with a shared sample tick and two-sample debounce.
module sw_debounce
  import sw_bist_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] d_raw,
  output logic [15:0] d_db
);

  localparam int            TW       = cnt_w(DEBOUNCE_CYC - 1);
  localparam logic [TW-1:0] TICK_MAX = TW'(DEBOUNCE_CYC - 1);

  logic [15:0]   sync1, sync2, samp;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [15:0]   agree;

  assign tick  = (tick_cnt == TICK_MAX);
  // A bit is accepted only when this sample matches the previous one.
  assign agree = ~(sync2 ^ samp);

  // Two-flop synchronizer on the raw switch pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= d_raw;
      sync2 <= sync1;
    end
  end

  // Free-running tick shared by all 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  // On each tick, take a new sample and update bits whose last two samples agree.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      samp <= '0;
      d_db <= '0;
    end else if (tick) begin
      samp <= sync2;
      d_db <= (sync2 & agree) | (d_db & ~agree);
    end
  end

endmodule

// File: rtl/sw_bist.sv
// Switch self-test: require all switches off, then see each go off->on->off.
module sw_bist
  import sw_bist_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TIMEOUT_S    = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] sw,
  output logic [15:0] led,
  output logic        busy,
  output logic        pass,
  output logic        fail
);

  localparam int              PW      = cnt_w(CLK_HZ - 1);
  localparam int              SECW    = cnt_w(TIMEOUT_S);
  localparam int              BW      = cnt_w(CLK_HZ / 2 - 1);
  localparam logic [PW-1:0]   PRE_MAX = PW'(CLK_HZ - 1);
  localparam logic [SECW-1:0] SEC_MAX = SECW'(TIMEOUT_S);
  localparam logic [BW-1:0]   BLK_MAX = BW'(CLK_HZ / 2 - 1);

  logic [15:0]     sw_db;
  logic            start_s1, start_s2, start_prev, start_edge;
  logic [BW-1:0]   blk_cnt;
  logic            blink;
  state_t          state;
  logic [15:0]     seen_hi, done;
  logic [PW-1:0]   pre_cnt;
  logic [SECW-1:0] sec_cnt;
  logic            expired, arm_go;

  sw_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db (
    .clk   (clk),
    .rst_n (rst_n),
    .d_raw (sw),
    .d_db  (sw_db)
  );

  // Start button synchronizer plus previous-value register for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_s1   <= 1'b0;
      start_s2   <= 1'b0;
      start_prev <= 1'b0;
    end else begin
      start_s1   <= start;
      start_s2   <= start_s1;
      start_prev <= start_s2;
    end
  end

  assign start_edge = start_s2 & ~start_prev;
  // Start is only honoured outside ARM/TEST.
  assign arm_go     = start_edge &&
                      (state == S_IDLE || state == S_PASS || state == S_FAIL);
  assign expired    = (sec_cnt == SEC_MAX);

  // 1 Hz blink, free-running from reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_cnt <= '0;
      blink   <= 1'b0;
    end else if (blk_cnt == BLK_MAX) begin
      blk_cnt <= '0;
      blink   <= ~blink;
    end else begin
      blk_cnt <= blk_cnt + BW'(1);
    end
  end

  // Test FSM with masks and the ARM-anchored timeout (progress never extends it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      seen_hi <= '0;
      done    <= '0;
      pre_cnt <= '0;
      sec_cnt <= '0;
    end else begin
      if (arm_go) begin
        pre_cnt <= '0;
        sec_cnt <= '0;
      end else if (pre_cnt == PRE_MAX) begin
        pre_cnt <= '0;
        if (!expired) sec_cnt <= sec_cnt + SECW'(1);
      end else begin
        pre_cnt <= pre_cnt + PW'(1);
      end

      case (state)
        S_ARM: begin
          seen_hi <= '0;
          done    <= '0;
          if (sw_db == '0)  state <= S_TEST;
          else if (expired) state <= S_FAIL;
        end
        S_TEST: begin
          seen_hi <= seen_hi | sw_db;
          done    <= done | (seen_hi & ~sw_db);
          // Completion beats a coincident timeout.
          if (done == LED_ALL) state <= S_PASS;
          else if (expired)    state <= S_FAIL;
        end
        S_IDLE, S_PASS, S_FAIL: begin
          if (arm_go) begin
            state   <= S_ARM;
            seen_hi <= '0;
            done    <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered outputs decoded from state and masks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led  <= '0;
      busy <= 1'b0;
      pass <= 1'b0;
      fail <= 1'b0;
    end else begin
      busy <= (state == S_ARM) || (state == S_TEST);
      pass <= (state == S_PASS);
      fail <= (state == S_FAIL);
      case (state)
        S_IDLE:  led <= sw_db;
        S_ARM:   led <= blink ? LED_ALL : '0;
        S_TEST:  led <= done;
        S_PASS:  led <= LED_ALL;
        S_FAIL:  led <= blink ? ~done : '0;
        default: led <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sw_bist.sv
// Directed bench for sw_bist with a queue-based output scoreboard.
module tb_sw_bist;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] sw;
  logic [15:0] led;
  logic        busy, pass, fail;

  int checks = 0;
  int errors = 0;

  string       q_name[$];
  logic [15:0] q_led[$];
  logic [15:0] q_mask[$];
  logic [2:0]  q_flg[$];

  sw_bist #(.CLK_HZ(100), .DEBOUNCE_CYC(4), .TIMEOUT_S(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sw    (sw),
    .led   (led),
    .busy  (busy),
    .pass  (pass),
    .fail  (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", n, got, exp);
    end
  endtask

  // Monitor: compares every queued expectation against the outputs at the falling edge.
  always @(negedge clk) begin
    string       n;
    logic [15:0] el, em;
    logic [2:0]  ef;
    while (q_name.size() > 0) begin
      n  = q_name.pop_front();
      el = q_led.pop_front();
      em = q_mask.pop_front();
      ef = q_flg.pop_front();
      chk(n, {13'd0, led & em, busy, pass, fail}, {13'd0, el & em, ef});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string n, input logic [15:0] l, input logic [15:0] m,
                            input logic b, input logic p, input logic f);
    q_name.push_back(n);
    q_led.push_back(l);
    q_mask.push_back(m);
    q_flg.push_back({b, p, f});
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(2);
    start = 1'b0;
  endtask

  task automatic wait_busy(input string n);
    int k;
    k = 0;
    while (busy !== 1'b1 && k < 20) begin
      step(1);
      k++;
    end
    chk(n, 32'(busy), 32'd1);
  endtask

  // Wait for led to reach all-ones in TEST, then check the pass timing around it.
  task automatic wait_pass(input string n, input bit strict);
    int k;
    bit partial;
    k = 0;
    partial = 1'b0;
    while (led !== 16'hFFFF && k < 40) begin
      if (strict && led !== 16'h0000) partial = 1'b1;
      step(1);
      k++;
    end
    if (strict) chk({n, "_allsame"}, 32'(partial), 32'd0);
    chk({n, "_reach"}, 32'(led === 16'hFFFF), 32'd1);
    expect_out({n, "_n1"}, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out({n, "_n2"}, 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);
  endtask

  // Over ~1.1 blink periods led must show only on_val and zero, and both of them.
  task automatic blink_check(input string n, input logic [15:0] on_val);
    bit seen_on, seen_off, other;
    seen_on = 1'b0;
    seen_off = 1'b0;
    other = 1'b0;
    for (int k = 0; k < 110; k++) begin
      if (led === on_val)        seen_on = 1'b1;
      else if (led === 16'h0000) seen_off = 1'b1;
      else                       other = 1'b1;
      step(1);
    end
    chk({n, "_on"}, 32'(seen_on), 32'd1);
    chk({n, "_off"}, 32'(seen_off), 32'd1);
    chk({n, "_other"}, 32'(other), 32'd0);
  endtask

  initial begin
    int cnt;
    bit bad;
    logic [15:0] m;

    rst_n = 1'b0;
    start = 1'b0;
    sw    = '0;
    step(3);
    expect_out("reset_state", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // IDLE mirrors the debounced switches.
    sw = 16'hA5A5;
    step(12);
    expect_out("idle_mirror", 16'hA5A5, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    sw = '0;
    step(12);
    expect_out("idle_clear", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);

    // Full pass, one switch at a time; start reaches busy four edges after the press.
    pulse_start();
    step(1);
    expect_out("start_lat_3", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(1);
    expect_out("start_lat_4", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    step(1);
    expect_out("test_entry", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      sw = 16'd1 << i;
      step(6);
      m = (16'd1 << i) - 16'd1;
      expect_out($sformatf("accum_%0d", i), m, 16'hFFFF, 1'b1, 1'b0, 1'b0);
      step(2);
      sw = '0;
      step(8);
    end
    wait_pass("full_pass", 1'b0);
    step(5);
    expect_out("pass_steady", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 1'b0);

    // Arm hold-off with a switch left on, then simultaneous toggle.
    sw = 16'h0010;
    step(12);
    pulse_start();
    wait_busy("arm_busy");
    blink_check("arm_blink", 16'hFFFF);
    expect_out("arm_hold", 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0);
    sw = '0;
    step(14);
    bad = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (led !== 16'h0000 || busy !== 1'b1) bad = 1'b1;
      step(1);
    end
    chk("arm_to_test", 32'(bad), 32'd0);
    sw = 16'hFFFF;
    step(12);
    sw = '0;
    wait_pass("simul", 1'b1);

    // Timeout with only the low byte exercised.
    pulse_start();
    wait_busy("to_busy");
    sw = 16'h00FF;
    step(12);
    sw = '0;
    step(14);
    cnt = 26;
    expect_out("to_partial", 16'h00FF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    while (fail !== 1'b1 && cnt < 400) begin
      step(1);
      cnt++;
    end
    chk("to_cycles", 32'(cnt), 32'd301);
    expect_out("to_fail", 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    blink_check("fail_blink", 16'hFF00);

    // Re-arm from FAIL clears masks; glitch earns nothing; start in TEST ignored.
    pulse_start();
    wait_busy("rearm_busy");
    step(2);
    expect_out("rearm_clear", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    sw = 16'h0008;
    step(1);
    sw = '0;
    step(25);
    expect_out("glitch", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    sw = 16'h0001;
    step(12);
    sw = '0;
    step(14);
    expect_out("retrig_pre", 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    pulse_start();
    step(12);
    expect_out("retrig_ign", 16'h0001, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Reset in the middle of TEST with the low byte done.
    sw = 16'h00FE;
    step(12);
    sw = '0;
    step(14);
    expect_out("rst_pre", 16'h00FF, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(1);
    rst_n = 1'b0;
    #1;
    expect_out("rst_async", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(3);
    sw = 16'h0F0F;
    rst_n = 1'b1;
    step(1);
    expect_out("rst_idle", 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(12);
    expect_out("rst_mirror", 16'h0F0F, 16'hFFFF, 1'b0, 1'b0, 1'b0);
    step(3);

    chk("queue_drained", 32'(q_name.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
